ilog2_stream: RTL and testbench

- Parametrised, fully pipelined floor(log2) unit for chaining gap-cost evaluation.
- Generalises the fixed 32-bit ilog2 pipeline in four ways: configurable data width, true valid/ready backpressure, a per-sample tag passthrough, and a per-sample half-log mode.
- Sits between the anchor-gap computation and the chain score accumulator.
- Sustains one result per cycle when not stalled.

---
 rtl/ilog2_stream.sv | 123 ++++++++++++
 tb/tb_ilog2_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ilog2_stream.sv
// ilog2_stream: pipelined floor(log2) with valid/ready backpressure, tag
// passthrough and an optional half-log result. A binary search narrows the
// operand down to a LUT_W-bit window, then a priority encoder finishes the job.
module ilog2_stream #(
    parameter int DATA_W = 32,
    parameter int LUT_W  = 8,
    parameter int TAG_W  = 8,
    localparam int LOG_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_half,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG_W-1:0]  out_log2,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);
    localparam int NSRCH  = $clog2(DATA_W / LUT_W);
    // Stage 0 accept, NSRCH search stages, table stage, output stage.
    localparam int STAGES = NSRCH + 2;

    if (DATA_W < 16 || DATA_W > 64 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
        $error("ilog2_stream: DATA_W must be a power of two in 16..64");
    end
    if (LUT_W < 2 || LUT_W >= DATA_W || (LUT_W & (LUT_W - 1)) != 0) begin : g_bad_lut_w
        $error("ilog2_stream: LUT_W must be a power of two below DATA_W");
    end

    typedef struct packed {
        logic [DATA_W-1:0] win;   // current search window, right-aligned
        logic [LOG_W-1:0]  acc;   // log accumulated so far
        logic [TAG_W-1:0]  tag;
        logic              half;
        logic              zero;
    } stage_t;

    logic [STAGES:0] vld_pipe;
    stage_t          st [0:NSRCH+1];
    logic            adv;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !flush;
    assign busy      = |vld_pipe;

    // One search step: window above 'hw' bits is always zero, so the upper
    // half is simply the window shifted down.
    function automatic stage_t search_step(stage_t s, int k);
        stage_t            r;
        logic [DATA_W-1:0] upper;
        int                hw;
        hw    = DATA_W >> k;
        r     = s;
        upper = s.win >> hw;
        if (upper != '0) begin
            r.win = upper;
            r.acc = s.acc + LOG_W'(hw);
        end else begin
            r.win = s.win & ~({DATA_W{1'b1}} << hw);
        end
        return r;
    endfunction

    // Priority encoder over the final window; an empty window yields 0.
    function automatic logic [LOG_W-1:0] lut_log2(logic [LUT_W-1:0] w);
        logic [LOG_W-1:0] r;
        r = '0;
        for (int i = 1; i < LUT_W; i++) begin
            if (w[i]) r = LOG_W'(i);
        end
        return r;
    endfunction

    function automatic stage_t table_step(stage_t s);
        stage_t r;
        r     = s;
        r.acc = s.acc + lut_log2(s.win[LUT_W-1:0]);
        return r;
    endfunction

    // Whole pipeline moves as one on adv; flush only kills the valid bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int i = 0; i <= NSRCH + 1; i++) st[i] <= '0;
            out_log2 <= '0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe     <= {vld_pipe[STAGES-1:0], in_valid};
            st[0].win    <= in_data;
            st[0].acc    <= '0;
            st[0].tag    <= in_tag;
            st[0].half   <= in_half;
            st[0].zero   <= (in_data == '0);
            for (int k = 1; k <= NSRCH; k++) st[k] <= search_step(st[k-1], k);
            st[NSRCH+1]  <= table_step(st[NSRCH]);
            out_zero     <= st[NSRCH+1].zero;
            out_tag      <= st[NSRCH+1].tag;
            if (st[NSRCH+1].zero)      out_log2 <= '0;
            else if (st[NSRCH+1].half) out_log2 <= st[NSRCH+1].acc >> 1;
            else                       out_log2 <= st[NSRCH+1].acc;
        end
    end

    // A stalled result must not change under the consumer.
    a_hold: assert property (@(posedge clk) disable iff (!reset)
        out_valid && !out_ready && !flush |=>
            out_valid && $stable(out_log2) && $stable(out_zero) && $stable(out_tag));

    // busy reflects exactly the set of occupied stages.
    a_busy: assert property (@(posedge clk) disable iff (!reset) busy == |vld_pipe);

endmodule

// File: tb/tb_ilog2_stream.sv
// Bench for ilog2_stream: scoreboard queues filled at accept time, monitors
// pop on each output handshake. Covers DATA_W=32 and a DATA_W=64 instance.
module tb_ilog2_stream;
    localparam int LAT_A = 4;
    localparam int LAT_B = 5;

    typedef struct {
        int exp_log;
        bit exp_zero;
        int tag;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, flush;
    logic in_valid, in_ready, in_half, out_valid, out_ready, out_zero, busy;
    logic [31:0] in_data;
    logic [7:0]  in_tag, out_tag;
    logic [4:0]  out_log2;

    logic b_flush, b_in_valid, b_in_ready, b_in_half, b_out_valid, b_out_ready, b_out_zero, b_busy;
    logic [63:0] b_in_data;
    logic [7:0]  b_in_tag, b_out_tag;
    logic [5:0]  b_out_log2;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   rnd_done;
    logic [4:0] s_log;
    logic [7:0] s_tag;
    logic       s_zero;

    ilog2_stream #(.DATA_W(32), .LUT_W(8), .TAG_W(8)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .in_half(in_half),
        .out_valid(out_valid), .out_ready(out_ready), .out_log2(out_log2),
        .out_zero(out_zero), .out_tag(out_tag), .busy(busy)
    );

    ilog2_stream #(.DATA_W(64), .LUT_W(8), .TAG_W(8)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_tag(b_in_tag), .in_half(b_in_half),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_log2(b_out_log2),
        .out_zero(b_out_zero), .out_tag(b_out_tag), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish (checks so far %0d)", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: count halvings until one remains; half mode halves the result.
    function automatic int ref_log2(input logic [63:0] v, input bit half);
        int l;
        logic [63:0] x;
        l = 0;
        x = v;
        while (x > 64'd1) begin
            x = x / 64'd2;
            l++;
        end
        return half ? l / 2 : l;
    endfunction

    // Present one sample from posedge+1; record it when the handshake will fire.
    task automatic send(input logic [31:0] d, input logic [7:0] t, input bit h);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_tag = t; in_half = h;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout_a", 0, 1);
        else qa.push_back('{exp_log: ref_log2({32'd0, d}, h), exp_zero: (d == 0),
                            tag: int'(t), acc_cyc: cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d, input logic [7:0] t, input bit h);
        int n;
        n = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_tag = t; b_in_half = h;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) chk("accept_timeout_b", 0, 1);
        else qb.push_back('{exp_log: ref_log2(d, h), exp_zero: (d == 0),
                            tag: int'(t), acc_cyc: cyc + 1});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (qa.size() == 0) chk("spurious_a", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("log2_a", out_log2, ea.exp_log);
                chk("zero_a", out_zero, ea.exp_zero);
                chk("tag_a", out_tag, ea.tag);
                if (lat_chk) chk("latency_a", cyc - ea.acc_cyc, LAT_A);
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (reset && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("spurious_b", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("log2_b", b_out_log2, eb.exp_log);
                chk("zero_b", b_out_zero, eb.exp_zero);
                chk("tag_b", b_out_tag, eb.tag);
                chk("latency_b", cyc - eb.acc_cyc, LAT_B);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_tag = '0; in_half = 1'b0; out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0; b_in_half = 1'b0;
        b_out_ready = 1'b1;
        #1 reset = 1'b0;
        #11;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_log2", out_log2, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Directed operands, full and half log, plus zero inputs.
        send(32'h0000_0001, 8'd1, 1'b0);
        send(32'h8000_0000, 8'd2, 1'b0);
        send(32'h0001_2345, 8'd3, 1'b0);
        send(32'h0000_00FF, 8'd4, 1'b0);
        send(32'h0000_0001, 8'd5, 1'b1);
        send(32'h8000_0000, 8'd6, 1'b1);
        send(32'h0001_2345, 8'd7, 1'b1);
        send(32'h0000_00FF, 8'd8, 1'b1);
        send(32'h0000_0000, 8'hA5, 1'b0);
        send(32'h0000_0000, 8'h5A, 1'b1);
        // Eight back-to-back single-bit operands.
        for (int t = 0; t < 8; t++) send(32'd1 << t, 8'(t), 1'b0);
        drain();

        // Mid-burst stall of five cycles.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send($urandom >> $urandom_range(0, 31), 8'(8'h20 + i), 1'($urandom % 2));
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_reach_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                #1 chk("stall_in_ready_drop", in_ready, 0);
                s_log = out_log2; s_tag = out_tag; s_zero = out_zero;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_log2", out_log2, s_log);
                    chk("stall_tag", out_tag, s_tag);
                    chk("stall_zero", out_zero, s_zero);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with samples in flight, one of them already at the output.
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) send(32'h100 << i, 8'(8'h40 + i), 1'b0);
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b0;
        qa.delete();
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", out_valid, 0);
        end
        @(posedge clk); #1;

        // Flush with three samples in flight and a competing input.
        for (int i = 0; i < 3; i++) send(32'h1000 << i, 8'(8'h50 + i), 1'b0);
        chk("pre_flush_busy", busy, 1);
        flush = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000_0007; in_tag = 8'hEE; in_half = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        qa.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_flush_quiet", out_valid, 0);
        end
        @(posedge clk); #1;

        // Random traffic with random input gaps and random backpressure.
        lat_chk = 1'b0;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send($urandom >> $urandom_range(0, 32), 8'($urandom), 1'($urandom % 2));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // 64-bit instance.
        send_b(64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 1'b0);
        send_b(64'h0000_0001_0000_0000, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++)
            send_b({$urandom, $urandom} >> $urandom_range(0, 64), 8'(10 + i), 1'($urandom % 2));
        drain();
        chk("b_idle", b_busy, 0);
        chk("a_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
